// File: rtl/pc_uart_sender.sv
// Streams NUM_BYTES bytes read from a sample ROM out of an 8N1 UART, LSB first.
// One ROM byte is fetched per frame; done pulses once after the final stop bit.
module pc_uart_sender #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned NUM_BYTES    = 98
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [6:0] rom_addr,
  input  logic [7:0] rom_q,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned BITS_W = 3;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_BYTES - 1);
  localparam logic [BITS_W-1:0] BIT_LAST  = BITS_W'(7);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START_BIT,
    DATA_BITS,
    STOP_BIT,
    DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [BAUD_W-1:0]   r_baud;
  logic [BITS_W-1:0]   r_bit_cnt;
  logic [7:0]          r_shift;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_tx;
  logic                r_busy;
  logic                r_done;
  logic                w_tx;
  logic                w_bit_end;
  logic                w_last_byte;

  assign w_bit_end   = (r_baud == BAUD_LAST);
  assign w_last_byte = (r_addr == ADDR_LAST);

  assign rom_addr = r_addr;
  assign tx       = r_tx;
  assign busy     = r_busy;
  assign done     = r_done;

  // Next-state and line level for the current state
  always_comb begin
    w_next = r_state;
    w_tx   = 1'b1;
    case (r_state)
      IDLE:      if (start) w_next = FETCH;
      FETCH:     w_next = LOAD;
      LOAD:      w_next = START_BIT;
      START_BIT: begin
        w_tx = 1'b0;
        if (w_bit_end) w_next = DATA_BITS;
      end
      DATA_BITS: begin
        w_tx = r_shift[0];
        if (w_bit_end && (r_bit_cnt == BIT_LAST)) w_next = STOP_BIT;
      end
      STOP_BIT:  if (w_bit_end) w_next = w_last_byte ? DONE : FETCH;
      DONE:      w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_baud    <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_addr    <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_tx    <= w_tx;
      r_busy  <= (r_state != IDLE);
      r_done  <= (r_state == DONE);
      case (r_state)
        IDLE: if (start) r_addr <= '0;
        LOAD: begin
          r_shift   <= rom_q;
          r_bit_cnt <= '0;
          r_baud    <= '0;
        end
        START_BIT: r_baud <= w_bit_end ? '0 : r_baud + BAUD_W'(1);
        DATA_BITS: begin
          r_baud <= w_bit_end ? '0 : r_baud + BAUD_W'(1);
          if (w_bit_end) begin
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + BITS_W'(1);
          end
        end
        STOP_BIT: begin
          r_baud <= w_bit_end ? '0 : r_baud + BAUD_W'(1);
          // Address stops at the last byte; DONE follows instead of a wrap
          if (w_bit_end && !w_last_byte) r_addr <= r_addr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/pc_uart_sender.md
PC_UART_SENDER -- requirements
Module: pc_uart_sender

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434: clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
REQ-002 Parameter NUM_BYTES, default 98: bytes per sample (784 binary pixels packed 8 per byte); legal range 1..128.
REQ-003 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1: synchronous, active-high reset.
REQ-005 Port start  input  1: request to transmit one full sample; sampled only in IDLE.
REQ-006 Port rom_addr  output  7: registered read address to the PC input sample ROM.
REQ-007 Port rom_q  input  8: ROM read data; valid one clock after rom_addr is sampled by the ROM.
REQ-008 Port tx  output  1: UART serial line, 8N1, LSB first, idle high; registered.
REQ-009 Port busy  output  1: high whenever state is not IDLE.
REQ-010 Port done  output  1: one-cycle pulse after the last stop bit of the sample.

Function
REQ-011 States SHALL be IDLE, FETCH, LOAD, START_BIT, DATA_BITS, STOP_BIT, DONE.
REQ-012 IDLE: tx=1, busy=0, done=0, rom_addr held; start=1 -> FETCH with rom_addr loaded to 0.
REQ-013 FETCH: one cycle; ROM samples rom_addr -> LOAD.
REQ-014 LOAD: one cycle; rom_q latched into 8-bit shift register, bit counter cleared, baud counter cleared -> START_BIT.
REQ-015 START_BIT: tx=0 for exactly CLKS_PER_BIT cycles -> DATA_BITS.
REQ-016 DATA_BITS: tx = shift[0], each bit held CLKS_PER_BIT cycles, shift right after each bit; after bit 7 -> STOP_BIT.
REQ-017 STOP_BIT: tx=1 for CLKS_PER_BIT cycles; then if rom_addr == NUM_BYTES-1 -> DONE, else rom_addr increments by 1 -> FETCH.
REQ-018 DONE: done=1 for exactly one cycle, busy=1, tx=1 -> IDLE.
REQ-019 Latency: tx first falls on the 3rd rising edge after the edge that samples start (IDLE->FETCH->LOAD->START_BIT).
REQ-020 Byte spacing: line high for CLKS_PER_BIT+2 cycles between consecutive frames (stop bit plus FETCH, LOAD).
REQ-021 Total sample time from start-sampling edge to done pulse: 2 + NUM_BYTES*(10*CLKS_PER_BIT+2) - 2 + 1 cycles, i.e. NUM_BYTES*(10*CLKS_PER_BIT+2)+1.
REQ-022 Baud counter width: ceil(log2(CLKS_PER_BIT)); counts 0..CLKS_PER_BIT-1, wraps to 0 on each bit boundary.
REQ-023 start asserted while busy=1 SHALL be ignored, including in DONE; no queuing.
REQ-024 start held high continuously SHALL begin a new sample on the cycle after DONE (IDLE sees start).
REQ-025 rom_addr SHALL never exceed NUM_BYTES-1; no wrap to 0 inside a sample.
REQ-026 rom_q SHALL be ignored in every state except LOAD.

Reset
REQ-027 rst=1 at a rising edge SHALL force state IDLE, tx=1, busy=0, done=0, rom_addr=0, shift register and counters 0, on that edge, overriding all other inputs.
REQ-028 Reset mid-frame SHALL abort the frame; tx returns high on the reset edge with no completion of the partial byte and no done pulse.
REQ-029 rst and start both high SHALL yield IDLE; start is ignored until the cycle after rst deasserts.

Verification (CLKS_PER_BIT=4, NUM_BYTES=3 unless noted)
REQ-030 Reset: rst high 2 cycles with start=1 -> tx=1, busy=0, done=0, rom_addr=0 throughout and after.
REQ-031 Single sample: ROM={0xA5,0x3C,0xFF}, start pulse -> tx falls 3 edges later; UART monitor decodes 0xA5,0x3C,0xFF; rom_addr sequence 0,1,2; done pulse at edge 3*42+1=127.
REQ-032 Timing: measure every bit width = 4 cycles, inter-frame high time = 6 cycles, busy high exactly 127 cycles.
REQ-033 Start while busy: extra start pulses mid-byte and during DONE -> no restart, byte stream unchanged, single done pulse.
REQ-034 Reset mid-operation: assert rst during DATA_BITS of byte 1 -> tx=1, busy=0 on that edge, no done; subsequent start resends from address 0.
REQ-035 Continuous start, NUM_BYTES=1, ROM[0]=0x00 -> back-to-back samples, one IDLE cycle between done and next FETCH, each frame start+8 zeros+stop.
